lut_ram_mp: RTL and testbench

Parametrised multi-read-port successor to the single-port LUT RAM, intended as the core's register-file storage. It adds several features over the single-port RAM:
- one synchronous write port with byte enables and N asynchronous read ports;
- optional write-first bypass;
- optional hardwired-zero address 0;
- a sequential clear engine that zeroes every entry after reset, since LUT RAM has no array reset.

---
 rtl/lut_ram_mp_if.sv | 27 ++
 rtl/lut_ram_mp.sv | 128 ++++++++++++
 tb/tb_lut_ram_mp.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_ram_mp_if.sv
// Bus bundle for lut_ram_mp: one byte-enabled write port, N packed read
// ports and the clear-complete flag. The master drives requests; the RAM is the slave.
interface lut_ram_mp_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 32,
    parameter int NUM_RD_PORTS = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                               wr_en;
    logic [AW-1:0]                      wr_addr;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic [DATA_WIDTH/8-1:0]            wr_byte_en;
    logic [NUM_RD_PORTS*AW-1:0]         rd_addr;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
    logic                               ready;

    modport master (
        output wr_en, wr_addr, wr_data, wr_byte_en, rd_addr,
        input  rd_data, ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_byte_en, rd_addr,
        output rd_data, ready
    );
endinterface

// File: rtl/lut_ram_mp.sv
// Multi-read-port LUT RAM for register-file storage. One synchronous
// byte-enabled write port, NUM_RD_PORTS combinational read ports, optional
// write-first forwarding, optional hardwired-zero entry 0, and a clear
// engine that zeroes every entry after reset because the array itself has no reset.
module lut_ram_mp #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter bit WR_FIRST     = 1'b1,
    parameter bit ZERO_ADDR0   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    lut_ram_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                             state_q, state_d;
    logic [AW-1:0]                      clr_cnt_q, clr_cnt_d;
    logic                               ready;
    logic                               user_we;
    logic [DATA_WIDTH-1:0]              wr_merged;
    logic                               mem_we;
    logic [AW-1:0]                      mem_waddr;
    logic [DATA_WIDTH-1:0]              mem_wdata;
    logic [AW-1:0]                      port_addr;
    logic [DATA_WIDTH-1:0]              port_word;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_d;

    // NOTE: the array has no reset; LUT RAM cannot be reset, so the clear engine zeroes it instead.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign ready     = (state_q == ST_READY);
    assign bus.ready = ready;

    // State register and clear counter; reset restarts the clear from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic: walk the counter through every entry, then go READY.
    always_comb begin
        // NOTE: defaults first, so no path leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Byte-merge the incoming write with the stored word; also used as the bypass value.
    always_comb begin
        wr_merged = mem[bus.wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (bus.wr_byte_en[b]) begin
                wr_merged[8*b +: 8] = bus.wr_data[8*b +: 8];
            end
        end
    end

    // User writes count only when ready; entry 0 is read-only when it is the zero register.
    assign user_we = ready && bus.wr_en && !(ZERO_ADDR0 && (bus.wr_addr == '0));

    // Write-port mux: the clear engine owns the port until ready, then the user does.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = wr_merged;
        if (!ready) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end else if (user_we) begin
            mem_we = 1'b1;
        end
    end

    // Array write; a whole pre-merged word is stored so the RAM stays a simple LUT RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read ports: array lookup, optional forwarding, zero register, and forced zero while clearing.
    always_comb begin
        rd_data_d = '0;
        port_addr = '0;
        port_word = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            port_addr = bus.rd_addr[p*AW +: AW];
            port_word = mem[port_addr];
            if (WR_FIRST && user_we && (port_addr == bus.wr_addr)) begin
                port_word = wr_merged;
            end
            if (ZERO_ADDR0 && (port_addr == '0)) begin
                port_word = '0;
            end
            if (!ready) begin
                port_word = '0;
            end
            rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = port_word;
        end
    end

    assign bus.rd_data = rd_data_d;
endmodule

// File: tb/tb_lut_ram_mp.sv
// Bench for lut_ram_mp. Two instances share the same stimulus: dut_a with
// forwarding and the zero register, dut_b with both disabled. A bench model
// predicts every read every cycle; directed checks pin the model to literal values.
module tb_lut_ram_mp;
    localparam int DW = 32;
    localparam int DP = 32;
    localparam int NP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0] be;
    logic [4:0] ra0, ra1;
    bit         chk_en;

    int vectors     = 0;
    int miscompares = 0;

    lut_ram_mp_if #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_RD_PORTS(NP)) if_a ();
    lut_ram_mp_if #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_RD_PORTS(NP)) if_b ();

    assign if_a.wr_en      = wr_en;
    assign if_a.wr_addr    = wr_addr;
    assign if_a.wr_data    = wr_data;
    assign if_a.wr_byte_en = be;
    assign if_a.rd_addr    = {ra1, ra0};
    assign if_b.wr_en      = wr_en;
    assign if_b.wr_addr    = wr_addr;
    assign if_b.wr_data    = wr_data;
    assign if_b.wr_byte_en = be;
    assign if_b.rd_addr    = {ra1, ra0};

    lut_ram_mp #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_RD_PORTS(NP),
                 .WR_FIRST(1'b1), .ZERO_ADDR0(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    lut_ram_mp #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_RD_PORTS(NP),
                 .WR_FIRST(1'b0), .ZERO_ADDR0(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Config 0 = dut_a (forwarding, zero register), config 1 = dut_b (plain).
    logic [31:0] m_mem [2][DP];
    int          m_cyc;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic bit m_ready();
        return !rst && (m_cyc >= DP);
    endfunction

    function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
        logic [31:0] v;
        if (!m_ready()) return 32'h0;
        if (c == 0 && a == 5'd0) return 32'h0;
        v = m_mem[c][a];
        if (c == 0 && wr_en && a == wr_addr) v = merge(v, wr_data, be);
        return v;
    endfunction

    // After reset the whole array reads zero; the first DP edges are the clear, writes dropped.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < DP; i++) m_mem[c][i] = 32'h0;
            m_cyc = 0;
        end else if (m_cyc < DP) begin
            m_cyc++;
        end else if (wr_en) begin
            if (wr_addr != 5'd0) m_mem[0][wr_addr] = merge(m_mem[0][wr_addr], wr_data, be);
            m_mem[1][wr_addr] = merge(m_mem[1][wr_addr], wr_data, be);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Every-cycle comparison, sampled between the input change and the next rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            #3;
            check("ready_a", {31'h0, if_a.ready}, {31'h0, m_ready()});
            check("ready_b", {31'h0, if_b.ready}, {31'h0, m_ready()});
            check("a_p0", if_a.rd_data[31:0],  exp_rd(0, ra0));
            check("a_p1", if_a.rd_data[63:32], exp_rd(0, ra1));
            check("b_p0", if_b.rd_data[31:0],  exp_rd(1, ra0));
            check("b_p1", if_b.rd_data[63:32], exp_rd(1, ra1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] e, input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        be      = e;
        ra0     = r0;
        ra1     = r1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!(if_a.ready === 1'b1 && if_b.ready === 1'b1) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, 32);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; be = '0;
        ra0 = '0; ra1 = '0; chk_en = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Clear with a write held during it: the write must be dropped.
        rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; be = 4'hF;
        ra0 = 5'd5; ra1 = 5'd0;
        wait_ready("clear_len");
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
        #2;
        check("dropped_a", if_a.rd_data[31:0], 32'h0);
        check("dropped_b", if_b.rd_data[31:0], 32'h0);

        // Byte enables.
        drive(1'b1, 5'd3, 32'h11223344, 4'b1111, 5'd9, 5'd9);
        drive(1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 5'd9, 5'd9);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3);
        #2;
        check("byte_en_a", if_a.rd_data[31:0],  32'h11BB33DD);
        check("byte_en_b", if_b.rd_data[63:32], 32'h11BB33DD);

        // Bypass vs read-old.
        drive(1'b1, 5'd7, 32'h77777777, 4'hF, 5'd9, 5'd9);
        drive(1'b1, 5'd8, 32'h00000808, 4'hF, 5'd9, 5'd9);
        drive(1'b1, 5'd7, 32'h000000A5, 4'hF, 5'd7, 5'd8);
        #2;
        check("bypass_a_p0", if_a.rd_data[31:0],  32'h000000A5);
        check("bypass_a_p1", if_a.rd_data[63:32], 32'h00000808);
        check("old_b_p0",    if_b.rd_data[31:0],  32'h77777777);
        check("old_b_p1",    if_b.rd_data[63:32], 32'h00000808);
        @(posedge clk);
        #1;
        check("after_edge_b_p0", if_b.rd_data[31:0], 32'h000000A5);

        // Zero register.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
        #2;
        check("zero_wr_a_p0", if_a.rd_data[31:0],  32'h0);
        check("zero_wr_a_p1", if_a.rd_data[63:32], 32'h0);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
        #2;
        check("zero_a_p0", if_a.rd_data[31:0],  32'h0);
        check("zero_a_p1", if_a.rd_data[63:32], 32'h0);
        check("addr0_b",   if_b.rd_data[31:0],  32'hFFFFFFFF);

        // Multiport sweep.
        for (int i = 1; i < 32; i++) drive(1'b1, 5'(i), 32'(i * 10), 4'hF, 5'(i), 5'(31 - i));
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i));
            #2;
            check("sweep_a_p0", if_a.rd_data[31:0],  (i == 0) ? 32'h0 : 32'(i * 10));
            check("sweep_a_p1", if_a.rd_data[63:32], (i == 31) ? 32'h0 : 32'((31 - i) * 10));
        end
        for (int i = 1; i < 32; i += 5) begin
            drive(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(i));
            #2;
            check("same_b_p0", if_b.rd_data[31:0],  32'(i * 10));
            check("same_b_p1", if_b.rd_data[63:32], 32'(i * 10));
        end

        // Reset during CLEAR at count 10.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rdy_a", {31'h0, if_a.ready}, 32'h0);
        check("async_rd_a",  if_a.rd_data[31:0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midclr_rdy_b", {31'h0, if_b.ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("reclear_len");
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd20);
        #2;
        check("wiped_b_p0", if_b.rd_data[31:0],  32'h0);
        check("wiped_b_p1", if_b.rd_data[63:32], 32'h0);

        // Reset in READY after writes.
        drive(1'b1, 5'd12, 32'hCAFEF00D, 4'hF, 5'd12, 5'd12);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd12, 5'd12);
        #2;
        check("pre_rst_a", if_a.rd_data[31:0], 32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_rst_rdy_a", {31'h0, if_a.ready}, 32'h0);
        check("ready_rst_rd_b",  if_b.rd_data[31:0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("ready_reclear_len");
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd12, 5'd12);
        #2;
        check("post_rst_a", if_a.rd_data[31:0],  32'h0);
        check("post_rst_b", if_b.rd_data[63:32], 32'h0);

        @(negedge clk);
        chk_en = 1'b0;
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
